divisor_sequencial: RTL and testbench
=====================================

Name: divisor_sequencial

Overview:
- Sequential restoring divider (shift-subtract-restore), the inverse of the team's shift-and-add multiplier.
- Contains its own control FSM and datapath: remainder register A, quotient/dividend register Q, divisor register B and an iteration counter.
- Uses the same start/done handshake as the multiplier, so both blocks plug into the same ALU sequencing logic.

Parameters:
N, 8, operand width in bits for dividend, divisor, quotient and remainder (N >= 2).

Ports:
clk  input  1  clock; all state changes on the rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  operation request; sampled in WAIT, level-sensitive handshake
dividend  input  N  unsigned dividend; sampled in LOAD only
divisor  input  N  unsigned divisor; sampled in LOAD only
quotient  output  N  Q register contents
remainder  output  N  A[N-1:0]
done  output  1  result valid; high only in DONE
busy  output  1  high in LOAD, SHIFT, SUB, TEST
div_zero  output  1  registered flag; last operation had divisor == 0

Behaviour:
- Registers:
  - A: N+1 bits (MSB is the sign of the trial subtraction).
  - Q, B: N bits each.
  - cnt: $clog2(N+1) bits.
  - state: 3 bits, with states WAIT, LOAD, SHIFT, SUB, TEST, DONE.
- Reset (async, any state, mid-operation included):
  - state=WAIT; A=0, Q=0, B=0, cnt=0, div_zero=0.
  - Outputs therefore: quotient=0, remainder=0, done=0, busy=0.
- WAIT:
  - start=1 -> LOAD; otherwise stay.
  - Datapath holds, so the previous result remains visible on quotient/remainder.
- LOAD (1 cycle):
  - If divisor != 0: A<=0, Q<=dividend, B<=divisor, cnt<=N, div_zero<=0; next state SHIFT.
  - If divisor == 0: Q<={N{1'b1}}, A<={1'b0,dividend}, B<=0, div_zero<=1; next state DONE (no iterations).
- SHIFT:
  - {A,Q} <= {A[N-1:0],Q,1'b0}, i.e. the 2N+1-bit pair shifts left by 1; A's MSB is dropped.
  - cnt<=cnt-1; next state SUB.
- SUB:
  - A <= A - {1'b0,B}, modulo 2^(N+1); next state TEST.
- TEST:
  - If A[N]==1 (negative): A <= A + {1'b0,B} (restore), Q[0]<=0.
  - Else: Q[0]<=1, A unchanged.
  - Next state: DONE if cnt==0, else SHIFT.
- DONE:
  - done=1, busy=0; all datapath registers hold.
  - Stay while start=1; start=0 -> WAIT. A new operation therefore needs start to drop and rise again.
- Output decode: done and busy are Moore outputs decoded from state; quotient, remainder and div_zero are register outputs (glitch-free).
- Latency, counted from the clock edge that samples start=1 in WAIT:
  - Normal operation: done rises after 2+3N edges (26 for N=8).
  - Divide by zero: done rises after 2 edges.
- start while busy: ignored; the operation is not restarted.
- dividend/divisor: may change freely outside LOAD without effect.
- Arithmetic invariant for divisor != 0: dividend == quotient*divisor + remainder, with remainder < divisor.
- Unused state encodings (3'b110, 3'b111): next state WAIT, outputs as in WAIT.

Test Plan:
- N=8, dividend=100, divisor=7, pulse start -> busy for 26 cycles; done=1 on edge 26; quotient=14, remainder=2, div_zero=0.
- Edge cases, one operation each:
  - 255/1 -> quotient=255, remainder=0.
  - 5/9 -> quotient=0, remainder=5.
  - 255/255 -> quotient=1, remainder=0.
  - 0/3 -> quotient=0, remainder=0.
- 200/0 -> done on edge 2; div_zero=1, quotient=255, remainder=200. Then a following 9/3 -> div_zero=0, quotient=3, remainder=0.
- start held high through and after DONE -> stays in DONE, no second operation. Drop start 1 cycle, raise again with new operands -> new result after 26 cycles.
- Assert rst mid-operation, in the SUB of iteration 4 -> all outputs 0 immediately (async), state WAIT. Start 50/6 afterwards -> quotient=8, remainder=2.
- Random sweep, 1000 operand pairs with nonzero divisor -> quotient*divisor+remainder==dividend and remainder<divisor each time. Toggling dividend/divisor during busy has no effect on results.

Source files
------------

// File: rtl/divisor_sequencial.sv
// Sequential restoring divider (shift / trial-subtract / restore) with start/done handshake.
// Shares the multiplier's handshake so both sit behind the same ALU sequencer.
//
// state | meaning
// WAIT  | idle, last result held on outputs
// LOAD  | capture operands, detect divide by zero
// SHIFT | shift {A,Q} left one bit, count iteration
// SUB   | trial subtract divisor from A
// TEST  | restore on negative A, set quotient bit
// DONE  | result valid, wait for start to drop
module divisor_sequencial #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         done,
  output logic         busy,
  output logic         div_zero
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [2:0] {
    S_WAIT  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_SUB   = 3'd3,
    S_TEST  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [N:0]      a_q, a_d;
  logic [N-1:0]    q_q, q_d;
  logic [N-1:0]    b_q, b_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            div_zero_q, div_zero_d;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    q_d        = q_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    div_zero_d = div_zero_q;
    case (state_q)
      S_WAIT: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (divisor != '0) begin
          a_d        = '0;
          q_d        = dividend;
          b_d        = divisor;
          cnt_d      = CW'(N);
          div_zero_d = 1'b0;
          state_d    = S_SHIFT;
        end else begin
          // Divide by zero: all-ones quotient, dividend passed through as remainder.
          a_d        = {1'b0, dividend};
          q_d        = '1;
          b_d        = '0;
          div_zero_d = 1'b1;
          state_d    = S_DONE;
        end
      end
      S_SHIFT: begin
        {a_d, q_d} = {a_q[N-1:0], q_q, 1'b0};
        cnt_d      = cnt_q - CW'(1);
        state_d    = S_SUB;
      end
      S_SUB: begin
        a_d     = a_q - {1'b0, b_q};
        state_d = S_TEST;
      end
      S_TEST: begin
        if (a_q[N]) begin
          a_d    = a_q + {1'b0, b_q};
          q_d[0] = 1'b0;
        end else begin
          q_d[0] = 1'b1;
        end
        state_d = (cnt_q == '0) ? S_DONE : S_SHIFT;
      end
      S_DONE: begin
        if (!start) state_d = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_WAIT;
      a_q        <= '0;
      q_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      q_q        <= q_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign quotient  = q_q;
  assign remainder = a_q[N-1:0];
  assign div_zero  = div_zero_q;
  assign done      = (state_q == S_DONE);
  assign busy      = (state_q == S_LOAD) || (state_q == S_SHIFT) ||
                     (state_q == S_SUB)  || (state_q == S_TEST);

endmodule

// File: tb/tb_divisor_sequencial.sv
// Self-checking bench for divisor_sequencial (N=8): vector table, corner sequences,
// and a random sweep with a result scoreboard.
module tb_divisor_sequencial;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         done;
  logic         busy;
  logic         div_zero;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
  } result_t;

  typedef struct packed {
    logic [N-1:0] dd;
    logic [N-1:0] dv;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
    int           lat;
  } vec_t;

  result_t sb[$];
  vec_t    vecs[7];

  divisor_sequencial #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .done      (done),
    .busy      (busy),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drives one operation; expected result must already be pushed to sb.
  task automatic run_op(input logic [N-1:0] dd, input logic [N-1:0] dv, input int exp_lat,
                        input bit hold, input bit scramble, input bit check_inv);
    int      lat;
    bit      got;
    bit      busy_ok;
    result_t exp;
    @(negedge clk);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    lat      = 0;
    got      = 1'b0;
    busy_ok  = 1'b1;
    while (lat < 100 && !got) begin
      @(posedge clk);
      #1;
      lat++;
      if (!hold) start = 1'b0;
      if (done) begin
        got = 1'b1;
        if (busy) busy_ok = 1'b0;
      end else begin
        if (!busy) busy_ok = 1'b0;
        if (scramble && lat >= 2) begin
          dividend = N'($urandom);
          divisor  = N'($urandom);
        end
      end
    end
    chk("latency", lat, exp_lat);
    chk("busy_during_op", int'(busy_ok), 1);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      exp = sb.pop_front();
      chk("quotient", int'(quotient), int'(exp.q));
      chk("remainder", int'(remainder), int'(exp.r));
      chk("div_zero", int'(div_zero), int'(exp.dz));
    end
    if (check_inv) begin
      chk("invariant_sum", int'(quotient) * int'(dv) + int'(remainder), int'(dd));
      chk("invariant_rem_lt_div", int'(remainder < dv), 1);
    end
    if (!hold) begin
      @(posedge clk);
      #1;
      chk("back_to_wait", int'({done, busy}), 0);
    end
  endtask

  initial begin
    bit      stay_ok;
    logic [N-1:0] q_hold;
    logic [N-1:0] rd;
    logic [N-1:0] rv;

    vecs[0] = '{dd: 8'd100, dv: 8'd7,   q: 8'd14,  r: 8'd2,   dz: 1'b0, lat: 26};
    vecs[1] = '{dd: 8'd255, dv: 8'd1,   q: 8'd255, r: 8'd0,   dz: 1'b0, lat: 26};
    vecs[2] = '{dd: 8'd5,   dv: 8'd9,   q: 8'd0,   r: 8'd5,   dz: 1'b0, lat: 26};
    vecs[3] = '{dd: 8'd255, dv: 8'd255, q: 8'd1,   r: 8'd0,   dz: 1'b0, lat: 26};
    vecs[4] = '{dd: 8'd0,   dv: 8'd3,   q: 8'd0,   r: 8'd0,   dz: 1'b0, lat: 26};
    vecs[5] = '{dd: 8'd200, dv: 8'd0,   q: 8'd255, r: 8'd200, dz: 1'b1, lat: 2};
    vecs[6] = '{dd: 8'd9,   dv: 8'd3,   q: 8'd3,   r: 8'd0,   dz: 1'b0, lat: 26};

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    chk("reset_outputs", int'({quotient, remainder, done, busy, div_zero}), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      sb.push_back('{q: vecs[i].q, r: vecs[i].r, dz: vecs[i].dz});
      run_op(vecs[i].dd, vecs[i].dv, vecs[i].lat, 1'b0, 1'b0, 1'b0);
    end

    // start held through DONE: no second operation
    sb.push_back('{q: 8'd15, r: 8'd2, dz: 1'b0});
    run_op(8'd77, 8'd5, 26, 1'b1, 1'b0, 1'b0);
    stay_ok = 1'b1;
    q_hold  = quotient;
    dividend = 8'd1;
    divisor  = 8'd1;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (!done || busy || quotient != q_hold) stay_ok = 1'b0;
    end
    chk("held_start_stays_done", int'(stay_ok), 1);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("start_drop_to_wait", int'({done, busy}), 0);
    sb.push_back('{q: 8'd8, r: 8'd4, dz: 1'b0});
    run_op(8'd60, 8'd7, 26, 1'b0, 1'b0, 1'b0);

    // async reset in SUB of iteration 4 (12 edges after start is sampled)
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    chk("busy_before_reset", int'(busy), 1);
    chk("partial_remainder_nonzero", int'(remainder != 0), 1);
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", int'({quotient, remainder, done, busy, div_zero}), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_after_reset", int'({done, busy}), 0);
    sb.push_back('{q: 8'd8, r: 8'd2, dz: 1'b0});
    run_op(8'd50, 8'd6, 26, 1'b0, 1'b0, 1'b0);

    // random sweep; odd iterations scramble operand inputs while busy
    for (int i = 0; i < 1000; i++) begin
      rd = N'($urandom);
      rv = N'($urandom_range(1, 255));
      sb.push_back('{q: rd / rv, r: rd % rv, dz: 1'b0});
      run_op(rd, rv, 26, 1'b0, bit'(i % 2), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
